// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with level tracking,
// programmable almost-full/almost-empty flags, registered read data with a
// valid strobe, and sticky overflow/underflow error flags.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_wr_en, i_wr_data       write request and data
//   i_rd_en                  read request
//   i_clr_err                clears sticky error flags (a new error wins)
//   o_rd_data, o_rd_valid    registered read data, one-cycle valid strobe
//   o_full, o_empty          level == DEPTH / level == 0
//   o_almost_full/_empty     level >= AF_THRESH / level <= AE_THRESH
//   o_level                  occupancy 0..DEPTH
//   o_overflow, o_underflow  sticky error flags
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR      = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [ADDR:0]    o_level,
  output logic             o_overflow,
  output logic             o_underflow
);

  // Thresholds narrowed to the level width so the flag compares are exact.
  localparam logic [31:0] AF_THRESH_U = AF_THRESH;
  localparam logic [31:0] AE_THRESH_U = AE_THRESH;
  localparam logic [ADDR:0] AF_LVL = AF_THRESH_U[ADDR:0];
  localparam logic [ADDR:0] AE_LVL = AE_THRESH_U[ADDR:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wptr;
  logic [ADDR:0]    rptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags depend on registered pointers only; the extra MSB distinguishes
  // full from empty when the address bits coincide.
  always_comb begin
    o_empty        = (wptr == rptr);
    o_full         = (wptr[ADDR] != rptr[ADDR]) &&
                     (wptr[ADDR-1:0] == rptr[ADDR-1:0]);
    o_level        = wptr - rptr;
    o_almost_full  = (o_level >= AF_LVL);
    o_almost_empty = (o_level <= AE_LVL);
    wr_acc         = i_wr_en && !o_full;
    rd_acc         = i_rd_en && !o_empty;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem  <= '{default: '0};
      wptr <= '0;
    end else if (wr_acc) begin
      mem[wptr[ADDR-1:0]] <= i_wr_data;
      wptr                <= wptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rptr       <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc;
      if (rd_acc) begin
        o_rd_data <= mem[rptr[ADDR-1:0]];
        rptr      <= rptr + 1'b1;
      end
    end
  end

  // Set has priority over clear so an error coinciding with i_clr_err
  // is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_en && o_full)      o_overflow <= 1'b1;
      else if (i_clr_err)         o_overflow <= 1'b0;
      if (i_rd_en && o_empty)     o_underflow <= 1'b1;
      else if (i_clr_err)         o_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a queue-based model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR  = 4;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, afull, aempty, ovf, udf;
  logic [ADDR:0]    level;

  int tests = 0;
  int fails = 0;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_clr_err(clr_err),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_full(full), .o_empty(empty),
    .o_almost_full(afull), .o_almost_empty(aempty),
    .o_level(level), .o_overflow(ovf), .o_underflow(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, outputs derived from its size.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_data  = '0;
  bit               m_valid = 1'b0;
  bit               m_ovf   = 1'b0;
  bit               m_udf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      int n;
      n = q.size();
      m_valid = 1'b0;
      if (wr_en && n == DEPTH)  m_ovf = 1'b1;
      else if (clr_err)         m_ovf = 1'b0;
      if (rd_en && n == 0)      m_udf = 1'b1;
      else if (clr_err)         m_udf = 1'b0;
      if (rd_en && n > 0) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end
      if (wr_en && n < DEPTH) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_level",    32'(level),    32'(n));
    chk("m_full",     32'(full),     32'(n == DEPTH));
    chk("m_empty",    32'(empty),    32'(n == 0));
    chk("m_afull",    32'(afull),    32'(n >= AF));
    chk("m_aempty",   32'(aempty),   32'(n <= AE));
    chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("m_rd_data",  32'(rd_data),  32'(m_data));
    chk("m_overflow", 32'(ovf),      32'(m_ovf));
    chk("m_underflow",32'(udf),      32'(m_udf));
  end

  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit clr);
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"},  32'(level),    32'd0);
    chk({tag, "_empty"},  32'(empty),    32'd1);
    chk({tag, "_full"},   32'(full),     32'd0);
    chk({tag, "_aempty"}, 32'(aempty),   32'd1);
    chk({tag, "_afull"},  32'(afull),    32'd0);
    chk({tag, "_valid"},  32'(rd_valid), 32'd0);
    chk({tag, "_data"},   32'(rd_data),  32'd0);
    chk({tag, "_ovf"},    32'(ovf),      32'd0);
    chk({tag, "_udf"},    32'(udf),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1;

    // Fill with 0x01..0x10.
    for (int i = 0; i < DEPTH; i++) begin
      w = WIDTH'(i + 1);
      step(1'b1, w, 1'b0, 1'b0);
      if (i == 0)  chk("empty_after_1st", 32'(empty), 32'd0);
      if (i == 10) chk("afull_after_11",  32'(afull), 32'd0);
      if (i == 11) chk("afull_after_12",  32'(afull), 32'd1);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);

    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set",     32'(ovf),   32'd1);
    chk("ovf_level",   32'(level), 32'd16);

    // Drain with idle cycles between reads to see the one-cycle strobe.
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_valid",  32'(rd_valid), 32'd1);
      chk("drain_data",   32'(rd_data),  32'(k + 1));
      chk("drain_aempty", 32'(aempty),   32'((15 - k) <= 2));
      step(1'b0, '0, 1'b0, 1'b0);
      chk("drain_strobe", 32'(rd_valid), 32'd0);
      chk("drain_hold",   32'(rd_data),  32'(k + 1));
    end
    chk("drained_empty",  32'(empty),  32'd1);
    chk("drained_aempty", 32'(aempty), 32'd1);

    // Simultaneous write+read on empty: write only.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("wr_rd_empty_udf",   32'(udf),      32'd1);
    chk("wr_rd_empty_level", 32'(level),    32'd1);
    chk("wr_rd_empty_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("a5_valid", 32'(rd_valid), 32'd1);
    chk("a5_data",  32'(rd_data),  32'h000000A5);

    // Steady state at level 5 across two pointer wraps.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      chk("stream_level", 32'(level), 32'd5);
      chk("stream_flags", {28'd0, full, empty, afull, aempty}, 32'd0);
    end

    // Error clearing, then clear colliding with a new overflow.
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_udf", 32'(udf), 32'd0);
    for (int i = 0; i < 11; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    chk("refill_full", 32'(full), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("clr_vs_ovf", 32'(ovf), 32'd1);

    // Async reset in the middle of a burst at level 7.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd7);
    wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_udf",   32'(udf),      32'd1);
    chk("post_rst_valid", 32'(rd_valid), 32'd0);
    chk("post_rst_data",  32'(rd_data),  32'd0);

    // Randomised traffic in phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 60; i++)
        step($urandom_range(99) < wp, WIDTH'($urandom),
             $urandom_range(99) < (100 - wp), $urandom_range(99) < 5);
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO (storage plus control) for same-domain buffering, e.g. register-file/ALU command queues.
- Adds what a bare dual-port storage array lacks:
  - pointer and level management
  - full/empty and programmable almost-full/almost-empty flags
  - registered read data with a valid strobe
  - sticky overflow/underflow error flags

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 4.
- ADDR, 4, address width; must equal log2(DEPTH).
- AF_THRESH, 12, o_almost_full asserts when level >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 2, o_almost_empty asserts when level <= AE_THRESH (range 0..DEPTH-1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  write request.
- i_wr_data  in  WIDTH  write data.
- i_rd_en  in  1  read request.
- i_clr_err  in  1  clears the sticky error flags.
- o_rd_data  out  WIDTH  registered read data.
- o_rd_valid  out  1  one-cycle strobe: o_rd_data holds a newly popped word.
- o_full  out  1  level == DEPTH.
- o_empty  out  1  level == 0.
- o_almost_full  out  1  level >= AF_THRESH.
- o_almost_empty  out  1  level <= AE_THRESH.
- o_level  out  ADDR+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - write/read pointers 0; all memory entries 0
  - o_rd_data 0, o_rd_valid 0
  - o_empty 1, o_full 0, o_level 0
  - o_almost_empty 1; o_almost_full 0
  - o_overflow 0, o_underflow 0
  - Asserting reset mid-operation discards all contents immediately. The first edge after release behaves as an empty FIFO.
- Pointers:
  - Pointers are ADDR+1 bits; the low ADDR bits address memory, and the MSB is a wrap bit.
  - o_empty = pointers equal.
  - o_full = MSBs differ and low bits equal.
  - o_level = wptr - rptr, modulo 2^(ADDR+1).
  - All flags and o_level are combinational functions of registered pointers only; there is no input-to-output combinational path.
- Write accept: i_wr_en && !o_full. Writes i_wr_data at wptr[ADDR-1:0] and increments wptr on the same edge.
- Read accept: i_rd_en && !o_empty. On that edge, o_rd_data <= mem[rptr[ADDR-1:0]], rptr increments, and o_rd_valid <= 1. Latency is 1 clock.
- When no read is accepted: o_rd_valid <= 0 and o_rd_data holds its last value.
- Simultaneous write and read:
  - Both accepted when neither full nor empty: level unchanged.
  - When full: the read is accepted and the write is rejected (overflow is set), so level becomes DEPTH-1. There is no pass-through.
  - When empty: the write is accepted and the read is rejected (underflow is set), so level becomes 1. There is no bypass; the word is readable from the next cycle.
- Wrap-around: pointers roll over naturally; full/empty stay correct across any number of wraps.
- Error flags:
  - o_overflow sets on i_wr_en && o_full.
  - o_underflow sets on i_rd_en && o_empty.
  - Both clear on i_clr_err. A set condition in the same cycle as i_clr_err wins, so the flag stays 1.
- Rejected operations leave pointers and memory unchanged.

Test Plan:
- Reset, then 16 writes of 0x01..0x10 with no reads:
  - o_full=1, o_level=16
  - o_almost_full first asserts after the 12th write
  - o_empty deasserts after the 1st write
- From full, one more write of 0xFF -> data rejected and o_overflow=1. Then 16 reads return 0x01..0x10, each with a one-cycle o_rd_valid the cycle after i_rd_en. Finally o_empty=1, o_almost_empty=1 at level<=2.
- From empty, i_wr_en=1 (0xA5) together with i_rd_en=1:
  - o_underflow=1, o_level=1, o_rd_valid=0
  - the next-cycle read returns 0xA5
- Continuous simultaneous read+write for 40 cycles at level 5 (wraps pointers twice) -> level stays 5, FIFO order is preserved, and the flags never toggle.
- i_clr_err pulse with no error condition -> both sticky flags cleared. Then i_clr_err together with a write-while-full -> o_overflow remains 1.
- Assert i_rst_n=0 asynchronously mid-burst at level 7:
  - all outputs immediately take their reset values
  - after release, the first read attempt sets underflow and returns no data
